// File: rtl/fifo_sync_flags.sv
`default_nettype none
// ============================================================================
// Module  : fifo_sync_flags
// Single-clock FIFO: arbitrary depth, fill count, almost-full/empty thresholds,
// FWFT or registered read, synchronous flush and sticky error flags.
// Rev     : 1.0
// ============================================================================
module fifo_sync_flags #(
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 8,
   parameter int FWFT     = 0,
   parameter int AF_LEVEL = DEPTH - 1,
   parameter int AE_LEVEL = 1,
   localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW      = $clog2(DEPTH + 1)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_flush,
   input  logic              i_wr_en,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_rd_en,
   input  logic              i_clr_err,
   output logic [DATA_W-1:0] o_data,
   output logic              o_valid,
   output logic              o_full,
   output logic              o_empty,
   output logic              o_almost_full,
   output logic              o_almost_empty,
   output logic [CW-1:0]     o_count,
   output logic              o_overflow,
   output logic              o_underflow
);

   localparam logic [AW-1:0] c_ptr_last = AW'(DEPTH - 1);
   localparam logic [CW-1:0] c_cnt_full = CW'(DEPTH);
   localparam logic [CW-1:0] c_af_level = CW'(AF_LEVEL);
   localparam logic [CW-1:0] c_ae_level = CW'(AE_LEVEL);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic              r_overflow;
   logic              r_underflow;
   logic              w_empty;
   logic              w_full;
   logic              w_rd_acc;
   logic              w_wr_acc;

   assign w_empty  = (r_count == '0);
   assign w_full   = (r_count == c_cnt_full);
   assign w_rd_acc = i_rd_en & ~w_empty;
   // A full FIFO still takes a write when a read frees a slot on the same edge
   assign w_wr_acc = i_wr_en & (~w_full | w_rd_acc);

   always_ff @(posedge i_clk) begin
      if (w_wr_acc && !i_flush) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         // Explicit wrap so non-power-of-2 depths index only valid entries
         if (w_wr_acc) begin
            r_wr_ptr <= (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + 1'b1;
         end
         if (w_rd_acc) begin
            r_rd_ptr <= (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + 1'b1;
         end
         case ({w_wr_acc, w_rd_acc})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Set has priority over clear; a flush cycle leaves the flags untouched
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else if (!i_flush) begin
         if (i_wr_en && !w_wr_acc) begin
            r_overflow <= 1'b1;
         end else if (i_clr_err) begin
            r_overflow <= 1'b0;
         end
         if (i_rd_en && w_empty) begin
            r_underflow <= 1'b1;
         end else if (i_clr_err) begin
            r_underflow <= 1'b0;
         end
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
         assign o_valid = ~w_empty;
      end else begin : g_reg
         logic [DATA_W-1:0] r_data;
         logic              r_valid;

         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               r_data  <= '0;
               r_valid <= 1'b0;
            end else if (i_flush) begin
               r_valid <= 1'b0;
            end else begin
               r_valid <= w_rd_acc;
               if (w_rd_acc) begin
                  r_data <= r_mem[r_rd_ptr];
               end
            end
         end

         assign o_data  = r_data;
         assign o_valid = r_valid;
      end
   endgenerate

   assign o_full         = w_full;
   assign o_empty        = w_empty;
   assign o_almost_full  = (r_count >= c_af_level);
   assign o_almost_empty = (r_count <= c_ae_level);
   assign o_count        = r_count;
   assign o_overflow     = r_overflow;
   assign o_underflow    = r_underflow;

endmodule
`default_nettype wire
